// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_arb_pkg : shared types and round-robin helper for axis_pkt_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package axis_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS  = 3'd1,
    GAP   = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } arb_state_t;

  localparam int ARB_TUSER_W = 12;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } rr_pick_t;

  // Walks the candidates from farthest to nearest so the nearest requester
  // after ptr overwrites the others; n is the live source count (<= 16).
  function automatic rr_pick_t rr_next(input logic [3:0] ptr, input logic [15:0] req, input int n);
    rr_pick_t pick;
    int       cand;
    pick = '0;
    for (int k = 16; k >= 1; k--) begin
      cand = (int'(ptr) + k) % n;
      if ((k <= n) && req[cand]) begin
        pick.valid = 1'b1;
        pick.idx   = 4'(cand);
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_select : combinational round-robin picker, first request after ptr wins
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_select
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  localparam int IDX_W  = $clog2(NUM_SRC)
) (
  input  logic [IDX_W-1:0]   ptr,
  input  logic [NUM_SRC-1:0] req,
  output logic [IDX_W-1:0]   sel_idx,
  output logic               sel_valid
);

  logic [3:0]  ptr_ext;
  logic [15:0] req_ext;
  rr_pick_t    pick;
  logic        unused_idx_bits;

  assign ptr_ext   = 4'(ptr);
  assign req_ext   = 16'(req);
  assign pick      = rr_next(ptr_ext, req_ext, NUM_SRC);
  assign sel_idx   = pick.idx[IDX_W-1:0];
  assign sel_valid = pick.valid;

  assign unused_idx_bits = ^pick.idx;

endmodule
`default_nettype wire

// File: rtl/axis_pkt_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_pkt_arbiter : packet-granular round-robin AXI-Stream arbiter with gap.
// Optional stall watchdog: define AXIS_ARB_TIMEOUT_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int USER_WIDTH     = ARB_TUSER_W,
  parameter int IDLE_GAP       = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W         = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_data,
  input  logic [NUM_SRC-1:0]            s_axis_valid,
  input  logic [NUM_SRC-1:0]            s_axis_last,
  input  logic [NUM_SRC*USER_WIDTH-1:0] s_axis_tuser,
  output logic [NUM_SRC-1:0]            s_axis_ready,
  output logic [DATA_WIDTH-1:0]         m_axis_data,
  output logic                          m_axis_valid,
  output logic                          m_axis_last,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  input  logic                          m_axis_ready,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_PASS  = PASS;
  localparam logic [2:0] ST_GAP   = GAP;
  localparam logic [2:0] ST_AFTER = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
  localparam logic [7:0] GAP_LAST = 8'(IDLE_GAP - 1);
`ifdef AXIS_ARB_TIMEOUT_EN
  localparam logic [2:0] ST_FLUSH = FLUSH;
  localparam logic [2:0] ST_DRAIN = DRAIN;
`endif

  logic [2:0]            state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      grant;
  logic [7:0]            gap_cnt;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_valid;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic [USER_WIDTH-1:0] g_user;
  logic                  pkt_done;

  rr_select #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_select (
    .ptr       (ptr),
    .req       (s_axis_valid),
    .sel_idx   (sel_idx),
    .sel_valid (sel_valid)
  );

  assign g_valid  = s_axis_valid[grant];
  assign g_last   = s_axis_last[grant];
  assign g_data   = s_axis_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign g_user   = s_axis_tuser[int'(grant)*USER_WIDTH +: USER_WIDTH];
  assign pkt_done = (state == ST_PASS) && g_valid && g_last && m_axis_ready;

`ifdef AXIS_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] stall_cnt;
  logic            abort;
  logic            timeout_pulse;

  // Any valid beat from the granted source, including a late tlast, clears the watchdog.
  assign abort = (state == ST_PASS) && !g_valid && (stall_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt     <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= abort;
      if ((state == ST_PASS) && !g_valid && !abort)
        stall_cnt <= stall_cnt + 1'b1;
      else
        stall_cnt <= '0;
    end
  end

  assign timeout_err = timeout_pulse;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      ptr     <= IDX_W'(NUM_SRC - 1);
      grant   <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            ptr   <= sel_idx;
            grant <= sel_idx;
            state <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (pkt_done) begin
            state   <= ST_AFTER;
            gap_cnt <= '0;
          end
`ifdef AXIS_ARB_TIMEOUT_EN
          else if (abort) begin
            state <= ST_FLUSH;
          end
`endif
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST)
            state <= ST_IDLE;
          else
            gap_cnt <= gap_cnt + 8'd1;
        end
`ifdef AXIS_ARB_TIMEOUT_EN
        ST_FLUSH: begin
          if (m_axis_ready)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (g_valid && g_last) begin
            state   <= ST_AFTER;
            gap_cnt <= '0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_axis_ready = '0;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    m_axis_data  = '0;
    m_axis_tuser = '0;
    case (state)
      ST_PASS: begin
        m_axis_valid        = g_valid;
        m_axis_last         = g_last;
        m_axis_data         = g_data;
        m_axis_tuser        = g_user;
        s_axis_ready[grant] = m_axis_ready;
      end
`ifdef AXIS_ARB_TIMEOUT_EN
      ST_FLUSH: begin
        m_axis_valid = 1'b1;
        m_axis_last  = 1'b1;
        m_axis_tuser = g_user;
      end
      ST_DRAIN: begin
        s_axis_ready[grant] = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign grant_id = grant;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axis_pkt_arbiter : randomized packet sources checked cycle by cycle
// against a packet-level round-robin reference model.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_axis_pkt_arbiter;

  localparam int NS   = 4;
  localparam int DW   = 8;
  localparam int UW   = 12;
  localparam int GAPC = 2;
  localparam int TMO  = 16;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic             clk;
  logic             reset;
  logic [NS*DW-1:0] s_axis_data;
  logic [NS-1:0]    s_axis_valid;
  logic [NS-1:0]    s_axis_last;
  logic [NS*UW-1:0] s_axis_tuser;
  logic [NS-1:0]    s_axis_ready;
  logic [DW-1:0]    m_axis_data;
  logic             m_axis_valid;
  logic             m_axis_last;
  logic [UW-1:0]    m_axis_tuser;
  logic             m_axis_ready;
  logic [1:0]       grant_id;
  logic             busy;
  logic             timeout_err;

  axis_pkt_arbiter #(
    .NUM_SRC        (NS),
    .DATA_WIDTH     (DW),
    .USER_WIDTH     (UW),
    .IDLE_GAP       (GAPC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_last  (s_axis_last),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_ready (s_axis_ready),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_last  (m_axis_last),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_ready (m_axis_ready),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int       checks = 0;
  int       errors = 0;
  int       cyc    = 0;
  beat_t    srcq[NS][$];
  logic [NS-1:0] pres;
  logic [NS-1:0] stall;
  bit       rdy_pat[$];
  int       rdy_pct = 100;
  int       vld_pct = 100;
  bit       chk_en  = 1'b1;

  // Reference model: who owns the egress, how much gap remains, last winner.
  int       owner;
  int       gap_left;
  int       ptr_m;
  int       last_grant;

  int       beats_out;
  int       first_beat_cyc;
  bit       in_pkt;
  logic [1:0] obs_order[$];

  function automatic bit any_pending();
    bit p = 1'b0;
    for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic add_pkt(input int src, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = {2'(src), 6'($urandom)};
      b.l = (k == len - 1);
      b.u = UW'(len);
      srcq[src].push_back(b);
    end
  endtask

  task automatic clear_obs();
    beats_out      = 0;
    first_beat_cyc = -1;
    in_pkt         = 1'b0;
    obs_order.delete();
  endtask

  // One clock: drive sources, check DUT against model, advance model and sources.
  task automatic cycle();
    logic [NS-1:0] er;
    logic          ev, el, mrdy, eb, found;
    logic [DW-1:0] ed;
    logic [UW-1:0] eu;
    logic [1:0]    eg;
    int            c;
    if (rdy_pat.size() > 0) mrdy = rdy_pat.pop_front();
    else                    mrdy = ($urandom_range(99) < rdy_pct);
    m_axis_ready = mrdy;
    for (int i = 0; i < NS; i++) begin
      if (!pres[i] && !stall[i] && srcq[i].size() > 0 && $urandom_range(99) < vld_pct)
        pres[i] = 1'b1;
      s_axis_valid[i]          = pres[i];
      s_axis_last[i]           = pres[i] ? srcq[i][0].l : 1'b0;
      s_axis_data[i*DW +: DW]  = pres[i] ? srcq[i][0].d : '0;
      s_axis_tuser[i*UW +: UW] = pres[i] ? srcq[i][0].u : '0;
    end
    #1;
    er = '0; ev = 1'b0; el = 1'b0; ed = '0; eu = '0;
    if (owner >= 0) begin
      ev        = s_axis_valid[owner];
      el        = s_axis_last[owner];
      ed        = s_axis_data[owner*DW +: DW];
      eu        = s_axis_tuser[owner*UW +: UW];
      er[owner] = mrdy;
    end
    eb = (owner >= 0) || (gap_left > 0);
    eg = 2'(last_grant);
    if (chk_en) begin
      checks++;
      if ({s_axis_ready, m_axis_valid, m_axis_last, m_axis_data, m_axis_tuser} !== {er, ev, el, ed, eu}) begin
        errors++;
        $display("FAIL egress cyc=%0d: got ready=%b valid=%b last=%b data=%h tuser=%0d, expected ready=%b valid=%b last=%b data=%h tuser=%0d",
                 cyc, s_axis_ready, m_axis_valid, m_axis_last, m_axis_data, m_axis_tuser, er, ev, el, ed, eu);
      end
      checks++;
      if ({grant_id, busy, timeout_err} !== {eg, eb, 1'b0}) begin
        errors++;
        $display("FAIL status cyc=%0d: got grant_id=%0d busy=%b timeout_err=%b, expected grant_id=%0d busy=%b timeout_err=0",
                 cyc, grant_id, busy, timeout_err, eg, eb);
      end
    end
    if (m_axis_valid && m_axis_ready) begin
      beats_out++;
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      if (!in_pkt) obs_order.push_back(m_axis_data[DW-1 -: 2]);
      in_pkt = !m_axis_last;
    end
    if (chk_en) begin
      if (owner >= 0) begin
        if (ev && mrdy && el) begin
          owner    = -1;
          gap_left = GAPC;
        end
      end else if (gap_left > 0) begin
        gap_left--;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= NS; k++) begin
          c = (ptr_m + k) % NS;
          if (!found && s_axis_valid[c]) begin
            found      = 1'b1;
            owner      = c;
            ptr_m      = c;
            last_grant = c;
          end
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (s_axis_valid[i] && s_axis_ready[i]) begin
        void'(srcq[i].pop_front());
        pres[i] = 1'b0;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n = 0;
    while ((any_pending() || owner >= 0 || gap_left > 0) && n < max_cyc) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL drain_bound: got still busy after %0d cycles, expected all packets forwarded", n);
    end
    cycle();
  endtask

  // Asserts reset mid-cycle with inputs untouched, checks outputs immediately.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({s_axis_ready, m_axis_valid, m_axis_last, m_axis_data, m_axis_tuser, grant_id, busy, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b valid=%b last=%b data=%h tuser=%0d grant_id=%0d busy=%b tmo=%b, expected all 0",
               s_axis_ready, m_axis_valid, m_axis_last, m_axis_data, m_axis_tuser, grant_id, busy, timeout_err);
    end
    for (int i = 0; i < NS; i++) srcq[i].delete();
    pres = '0; stall = '0;
    s_axis_valid = '0; s_axis_last = '0; s_axis_data = '0; s_axis_tuser = '0;
    m_axis_ready = 1'b0;
    rdy_pat.delete();
    rdy_pct = 100; vld_pct = 100;
    owner = -1; gap_left = 0; ptr_m = NS - 1; last_grant = 0;
    clear_obs();
    @(negedge clk);
    cyc++;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (3) cycle();
  endtask

  task automatic test_single_source();
    int start;
    apply_reset();
    add_pkt(2, 35);
    start = cyc;
    run_until_idle(200);
    checks++;
    if (beats_out !== 35) begin
      errors++; $display("FAIL single_beats: got %0d beats, expected 35", beats_out);
    end
    checks++;
    if (first_beat_cyc !== start + 1) begin
      errors++; $display("FAIL single_latency: got first beat %0d cycles after valid, expected 1", first_beat_cyc - start);
    end
    checks++;
    if (obs_order.size() != 1 || obs_order[0] !== 2'd2 || grant_id !== 2'd2) begin
      errors++; $display("FAIL single_grant: got %0d packets grant_id=%0d, expected 1 packet from source 2", obs_order.size(), grant_id);
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < NS; s++) add_pkt(s, 3);
    run_until_idle(300);
    checks++;
    if (obs_order.size() != 12) begin
      errors++; $display("FAIL fair_count: got %0d packets, expected 12", obs_order.size());
    end
    for (int k = 0; k < obs_order.size(); k++) begin
      checks++;
      if (obs_order[k] !== 2'(k % NS)) begin
        errors++; $display("FAIL fair_order[%0d]: got source %0d, expected source %0d", k, obs_order[k], k % NS);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    add_pkt(3, 5);
    rdy_pat.push_back(1'b1);
    for (int r = 0; r < 4; r++) begin
      rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0);
      rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
    end
    run_until_idle(100);
    checks++;
    if (beats_out !== 5 || obs_order.size() != 1) begin
      errors++; $display("FAIL bp_beats: got %0d beats in %0d packets, expected 5 in 1", beats_out, obs_order.size());
    end
  endtask

  task automatic test_mid_grant();
    apply_reset();
    add_pkt(1, 6);
    repeat (3) cycle();
    add_pkt(0, 2);
    run_until_idle(100);
    checks++;
    if (obs_order.size() != 2 || obs_order[0] !== 2'd1 || obs_order[1] !== 2'd0) begin
      errors++; $display("FAIL mid_grant_order: got %0d packets first=%0d, expected source 1 then source 0",
                         obs_order.size(), obs_order.size() > 0 ? obs_order[0] : 2'd0);
    end
  endtask

  task automatic test_reset_mid_packet();
    int n = 0;
    apply_reset();
    add_pkt(2, 10);
    while (beats_out < 2 && n < 50) begin cycle(); n++; end
    apply_reset();
    add_pkt(3, 2);
    add_pkt(1, 2);
    run_until_idle(100);
    checks++;
    if (obs_order.size() != 2 || obs_order[0] !== 2'd1) begin
      errors++; $display("FAIL reset_regrant: got %0d packets first=%0d, expected source 1 first",
                         obs_order.size(), obs_order.size() > 0 ? obs_order[0] : 2'd0);
    end
  endtask

  task automatic test_random();
    int total = 0;
    int len;
    apply_reset();
    rdy_pct = 70;
    vld_pct = 60;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 6);
      total += len;
      add_pkt($urandom_range(0, NS - 1), len);
    end
    run_until_idle(3000);
    checks++;
    if (beats_out !== total) begin
      errors++; $display("FAIL random_beats: got %0d beats, expected %0d", beats_out, total);
    end
  endtask

`ifdef AXIS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int  n = 0;
    int  pulses = 0;
    int  drain_valid = 0;
    bit  flushed = 1'b0;
    bit  flush_ok = 1'b0;
    apply_reset();
    chk_en = 1'b0;
    add_pkt(0, 8);
    while (beats_out < 4 && n < 50) begin cycle(); n++; end
    stall[0] = 1'b1;
    n = 0;
    while (!flushed && n < 60) begin
      if (timeout_err) pulses++;
      if (m_axis_valid && m_axis_ready && pulses > 0) begin
        flushed  = 1'b1;
        flush_ok = (m_axis_data == '0) && m_axis_last && (m_axis_tuser == UW'(8));
      end
      cycle();
      n++;
    end
    stall[0] = 1'b0;
    n = 0;
    while ((busy || srcq[0].size() > 0) && n < 60) begin
      if (timeout_err) pulses++;
      if (m_axis_valid) drain_valid++;
      cycle();
      n++;
    end
    checks++;
    if (pulses !== 1 || !flush_ok || drain_valid !== 0 || srcq[0].size() != 0 || busy) begin
      errors++; $display("FAIL timeout: got pulses=%0d flush_ok=%b drain_valid=%0d left=%0d busy=%b, expected 1/1/0/0/0",
                         pulses, flush_ok, drain_valid, srcq[0].size(), busy);
    end
    chk_en = 1'b1;
  endtask
`endif

  initial begin
    reset = 1'b1;
    s_axis_valid = '0; s_axis_last = '0; s_axis_data = '0; s_axis_tuser = '0;
    m_axis_ready = 1'b0;
    pres = '0; stall = '0;
    owner = -1; gap_left = 0; ptr_m = NS - 1; last_grant = 0;
    clear_obs();
    @(negedge clk);
    test_reset();
    test_single_source();
    test_fairness();
    test_backpressure();
    test_mid_grant();
    test_reset_mid_packet();
    test_random();
`ifdef AXIS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
